// File: rtl/wb_stage_regfile.sv
// Y86-64 PIPE write-back stage: W pipeline register, destination decode and a 2W/2R register file.
// Optional macro WB_BYPASS_EN makes the read ports write-through from the W register.
module wb_stage_regfile #(
  parameter int DATA_W = 64,
  parameter int NREG   = 15,
  parameter int RNONE  = 15,
  parameter int RSP    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        m_stat,
  input  logic [3:0]        m_icode,
  input  logic              m_cnd,
  input  logic [DATA_W-1:0] m_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [3:0]        m_rA,
  input  logic [3:0]        m_rB,
  input  logic              W_stall,
  input  logic              W_bubble,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] rvalA,
  output logic [DATA_W-1:0] rvalB,
  output logic [2:0]        W_stat,
  output logic [3:0]        W_icode,
  output logic [3:0]        W_dstE,
  output logic [3:0]        W_dstM,
  output logic [DATA_W-1:0] W_valE,
  output logic [DATA_W-1:0] W_valM,
  output logic              halted
);

  localparam logic [3:0] RNONE_ID = 4'(RNONE);
  localparam logic [3:0] RSP_ID   = 4'(RSP);
  localparam logic [4:0] NREG_L   = 5'(NREG);
  localparam logic [2:0] STAT_AOK = 3'd1;

  function automatic logic id_valid(input logic [3:0] id);
    return ({1'b0, id} < NREG_L);
  endfunction

  function automatic logic [3:0] clamp_id(input logic [3:0] id);
    if (id_valid(id)) begin
      return id;
    end else begin
      return RNONE_ID;
    end
  endfunction

  // cmovXX (icode 2) only targets rB when its condition held
  function automatic logic [3:0] decode_dste(input logic [3:0] icode, input logic cnd,
                                             input logic [3:0] rb);
    logic [3:0] d;
    case (icode)
      4'd3, 4'd6:               d = rb;
      4'd2:                     d = cnd ? rb : RNONE_ID;
      4'd8, 4'd9, 4'd10, 4'd11: d = RSP_ID;
      default:                  d = RNONE_ID;
    endcase
    return clamp_id(d);
  endfunction

  function automatic logic [3:0] decode_dstm(input logic [3:0] icode, input logic [3:0] ra);
    logic [3:0] d;
    case (icode)
      4'd5, 4'd11: d = ra;
      default:     d = RNONE_ID;
    endcase
    return clamp_id(d);
  endfunction

  logic [2:0]        w_stat_r;
  logic [3:0]        w_icode_r;
  logic [3:0]        w_dste_r;
  logic [3:0]        w_dstm_r;
  logic [DATA_W-1:0] w_vale_r;
  logic [DATA_W-1:0] w_valm_r;
  logic              halted_r;
  logic [DATA_W-1:0] regs_r [0:NREG-1];
  logic              we_s;
  logic              dste_ok_s;
  logic              dstm_ok_s;
  logic [DATA_W-1:0] rvala_s;
  logic [DATA_W-1:0] rvalb_s;

  // W pipeline register; destinations are decoded on capture so W_dst* come straight from flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_stat_r  <= STAT_AOK;
      w_icode_r <= 4'd1;
      w_dste_r  <= RNONE_ID;
      w_dstm_r  <= RNONE_ID;
      w_vale_r  <= '0;
      w_valm_r  <= '0;
    end else if (W_bubble) begin
      w_stat_r  <= STAT_AOK;
      w_icode_r <= 4'd1;
      w_dste_r  <= RNONE_ID;
      w_dstm_r  <= RNONE_ID;
      w_vale_r  <= '0;
      w_valm_r  <= '0;
    end else if (!W_stall) begin
      w_stat_r  <= m_stat;
      w_icode_r <= m_icode;
      w_dste_r  <= decode_dste(m_icode, m_cnd, m_rB);
      w_dstm_r  <= decode_dstm(m_icode, m_rA);
      w_vale_r  <= m_valE;
      w_valm_r  <= m_valM;
    end else begin
      w_stat_r  <= w_stat_r;
      w_icode_r <= w_icode_r;
      w_dste_r  <= w_dste_r;
      w_dstm_r  <= w_dstm_r;
      w_vale_r  <= w_vale_r;
      w_valm_r  <= w_valm_r;
    end
  end

  assign we_s      = (w_stat_r == STAT_AOK) && !halted_r;
  assign dste_ok_s = id_valid(w_dste_r);
  assign dstm_ok_s = id_valid(w_dstm_r);

  // Sticky halt: any HLT/ADR/INS status reaching write-back freezes architectural state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_r <= 1'b0;
    end else if ((w_stat_r == 3'd2) || (w_stat_r == 3'd3) || (w_stat_r == 3'd4)) begin
      halted_r <= 1'b1;
    end else begin
      halted_r <= halted_r;
    end
  end

  // Register file write ports; M overrides E on a shared destination (popq %rsp)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else if (we_s) begin
      if (dste_ok_s && (w_dste_r != w_dstm_r)) begin
        regs_r[w_dste_r] <= w_vale_r;
      end
      if (dstm_ok_s) begin
        regs_r[w_dstm_r] <= w_valm_r;
      end
    end
  end

  // Combinational decode read ports
  always_comb begin
    rvala_s = '0;
    rvalb_s = '0;
    if (id_valid(srcA)) begin
      rvala_s = regs_r[srcA];
    end else begin
      rvala_s = '0;
    end
    if (id_valid(srcB)) begin
      rvalb_s = regs_r[srcB];
    end else begin
      rvalb_s = '0;
    end
`ifdef WB_BYPASS_EN
    if (we_s && dstm_ok_s && (srcA == w_dstm_r)) begin
      rvala_s = w_valm_r;
    end else if (we_s && dste_ok_s && (srcA == w_dste_r)) begin
      rvala_s = w_vale_r;
    end else begin
      rvala_s = rvala_s;
    end
    if (we_s && dstm_ok_s && (srcB == w_dstm_r)) begin
      rvalb_s = w_valm_r;
    end else if (we_s && dste_ok_s && (srcB == w_dste_r)) begin
      rvalb_s = w_vale_r;
    end else begin
      rvalb_s = rvalb_s;
    end
`endif
  end

  assign rvalA   = rvala_s;
  assign rvalB   = rvalb_s;
  assign W_stat  = w_stat_r;
  assign W_icode = w_icode_r;
  assign W_dstE  = w_dste_r;
  assign W_dstM  = w_dstm_r;
  assign W_valE  = w_vale_r;
  assign W_valM  = w_valm_r;
  assign halted  = halted_r;

endmodule
